// File: rtl/writeback_unit_if.sv
// Writeback bus: groups the memory-stage result handshake and the
// register-file / PC write port that the writeback unit drives.
//
//   env modport   : upstream stage and register file (drives in_* and rf_ready)
//   slave modport : the writeback unit (drives in_ready, rf_*, pc_*)
//
//   in_valid/in_ready   result handshake
//   in_result           result value, or branch target when in_is_branch
//   in_is_branch        result is a jump/branch target
//   in_write_rd         result (or link) is written to rd
//   in_rd               destination register
//   in_end_program      final instruction marker
//   rf_ready            register file / PC accept the held entry
//   rf_we/waddr/wdata   register write port
//   pc_we/pc_wdata      PC redirect port
interface writeback_unit_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_result;
  logic              in_is_branch;
  logic              in_write_rd;
  logic [REG_AW-1:0] in_rd;
  logic              in_end_program;
  logic              rf_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              pc_we;
  logic [XLEN-1:0]   pc_wdata;

  modport env (
    output in_valid, in_result, in_is_branch, in_write_rd, in_rd,
           in_end_program, rf_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata
  );

  modport slave (
    input  in_valid, in_result, in_is_branch, in_write_rd, in_rd,
           in_end_program, rf_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage between the memory stage and the register file / PC.
// Holds one result in an output register, commits it when the register
// file accepts it, keeps forwarding capture buffers of the last committed
// value, counts retired instructions and runs a RUN/DRAIN/DONE halt FSM.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             writeback_unit_if.slave (result handshake + rf/pc writes)
//   fwd_capture     per-buffer capture strobe
//   fwd_buf         capture buffers, buffer i at [i*XLEN +: XLEN]
//   last_value      most recently committed register write data
//   retired_count   committed instruction count (saturating)
//   done_executing  program has ended and drained
module writeback_unit #(
  parameter int XLEN        = 64,
  parameter int REG_AW      = 5,
  parameter int NUM_FWD_BUF = 2,
  parameter int CNT_W       = 32,
  parameter int INSN_BYTES  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  writeback_unit_if.slave             bus,
  input  logic [NUM_FWD_BUF-1:0]      fwd_capture,
  output logic [NUM_FWD_BUF*XLEN-1:0] fwd_buf,
  output logic [XLEN-1:0]             last_value,
  output logic [CNT_W-1:0]            retired_count,
  output logic                        done_executing
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [XLEN-1:0] link_value(input logic [XLEN-1:0] tgt);
    return tgt + XLEN'(INSN_BYTES);
  endfunction

  logic              acc, commit;
  logic [XLEN-1:0]   target_p0, wdata_p0;
  logic              we_p0;

  logic              vld_p1;
  logic              we_p1, br_p1, end_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [XLEN-1:0]   wdata_p1, target_p1;

  // Stage p0: decode the incoming result
  assign bus.in_ready = !rst && (state == RUN) && (!vld_p1 || bus.rf_ready);
  assign acc          = bus.in_valid && bus.in_ready;
  assign commit       = vld_p1 && bus.rf_ready;

  // Branch targets are halfword aligned; the link value is the next insn.
  assign target_p0 = {bus.in_result[XLEN-1:1], 1'b0};
  assign wdata_p0  = bus.in_is_branch ? link_value(target_p0) : bus.in_result;
  assign we_p0     = bus.in_write_rd && (bus.in_rd != '0);

  // Stage p1: one-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (acc) begin
      vld_p1 <= 1'b1;
    end else if (commit) begin
      vld_p1 <= 1'b0;
    end
  end

  // Payload needs no reset: every output derived from it is gated by vld_p1.
  always_ff @(posedge clk) begin
    if (acc) begin
      we_p1     <= we_p0;
      br_p1     <= bus.in_is_branch;
      end_p1    <= bus.in_end_program;
      rd_p1     <= bus.in_rd;
      wdata_p1  <= wdata_p0;
      target_p1 <= target_p0;
    end
  end

  assign bus.rf_we    = vld_p1 && we_p1;
  assign bus.rf_waddr = vld_p1 ? rd_p1 : '0;
  assign bus.rf_wdata = vld_p1 ? wdata_p1 : '0;
  assign bus.pc_we    = vld_p1 && br_p1;
  assign bus.pc_wdata = vld_p1 ? target_p1 : '0;

  // Commit bookkeeping; buffers sample last_value before this edge's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count <= '0;
      last_value    <= '0;
      fwd_buf       <= '0;
    end else begin
      if (commit) begin
        retired_count <= sat_inc(retired_count);
        if (we_p1) begin
          last_value <= wdata_p1;
        end
      end
      for (int i = 0; i < NUM_FWD_BUF; i++) begin
        if (fwd_capture[i]) begin
          fwd_buf[i*XLEN +: XLEN] <= last_value;
        end
      end
    end
  end

  // Halt FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (acc && bus.in_end_program) state_nxt = DRAIN;
      DRAIN:   if (commit && end_p1)          state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  assign done_executing = (state == DONE);

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NB   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NB-1:0]      fwd_capture = '0;
  logic [NB*XLEN-1:0] fwd_buf, fwd_buf2;
  logic [XLEN-1:0]    last_value, last_value2;
  logic [31:0]        retired_count;
  logic [1:0]         retired_count2;
  logic               done_executing, done2;

  always #5 clk = ~clk;

  writeback_unit_if #(.XLEN(XLEN), .REG_AW(AW)) bus ();
  writeback_unit_if #(.XLEN(XLEN), .REG_AW(AW)) bus2 ();

  assign bus2.in_valid       = bus.in_valid;
  assign bus2.in_result      = bus.in_result;
  assign bus2.in_is_branch   = bus.in_is_branch;
  assign bus2.in_write_rd    = bus.in_write_rd;
  assign bus2.in_rd          = bus.in_rd;
  assign bus2.in_end_program = bus.in_end_program;
  assign bus2.rf_ready       = bus.rf_ready;

  writeback_unit #(.XLEN(XLEN), .REG_AW(AW), .NUM_FWD_BUF(NB), .CNT_W(32), .INSN_BYTES(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fwd_capture(fwd_capture), .fwd_buf(fwd_buf),
    .last_value(last_value), .retired_count(retired_count), .done_executing(done_executing));

  writeback_unit #(.XLEN(XLEN), .REG_AW(AW), .NUM_FWD_BUF(NB), .CNT_W(2), .INSN_BYTES(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2), .fwd_capture(fwd_capture), .fwd_buf(fwd_buf2),
    .last_value(last_value2), .retired_count(retired_count2), .done_executing(done2));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: at most one pending item between accept and commit.
  bit          live = 0;
  bit          m_held, m_ended, m_done;
  bit          m_we, m_br, m_end;
  logic [4:0]  m_rd;
  logic [63:0] m_wdata, m_tgt, m_last, m_buf0, m_buf1, m_old;
  longint unsigned m_count;
  int          m_cnt2;
  bit          m_acc, m_commit;

  always @(posedge clk) begin
    if (rst) begin
      live = 1; m_held = 0; m_ended = 0; m_done = 0;
      m_count = 0; m_cnt2 = 0; m_last = 0; m_buf0 = 0; m_buf1 = 0;
    end else if (live) begin
      m_acc    = bus.in_valid && !m_ended && (!m_held || bus.rf_ready);
      m_commit = m_held && bus.rf_ready;
      m_old    = m_last;
      if (fwd_capture[0]) m_buf0 = m_old;
      if (fwd_capture[1]) m_buf1 = m_old;
      if (m_commit) begin
        if (m_count < 64'hFFFF_FFFF) m_count++;
        if (m_cnt2 < 3) m_cnt2++;
        if (m_we) m_last = m_wdata;
        if (m_end) m_done = 1;
        m_held = 0;
      end
      if (m_acc) begin
        m_held = 1;
        m_tgt  = bus.in_result & ~64'd1;
        m_wdata = bus.in_is_branch ? m_tgt + 64'd4 : bus.in_result;
        m_we   = bus.in_write_rd && (bus.in_rd != 0);
        m_br   = bus.in_is_branch;
        m_end  = bus.in_end_program;
        m_rd   = bus.in_rd;
        if (m_end) m_ended = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", bus.in_ready, !rst && !m_ended && (!m_held || bus.rf_ready));
      chk("rf_we", bus.rf_we, m_held && m_we);
      chk("rf_waddr", bus.rf_waddr, m_held ? m_rd : 5'd0);
      chk("rf_wdata", bus.rf_wdata, m_held ? m_wdata : 64'd0);
      chk("pc_we", bus.pc_we, m_held && m_br);
      chk("pc_wdata", bus.pc_wdata, m_held ? m_tgt : 64'd0);
      chk("last_value", last_value, m_last);
      chk("fwd_buf0", fwd_buf[63:0], m_buf0);
      chk("fwd_buf1", fwd_buf[127:64], m_buf1);
      chk("retired_count", retired_count, m_count);
      chk("retired_count_sat", retired_count2, m_cnt2);
      chk("done_executing", done_executing, m_done);
    end
  end

  // Set inputs, then advance to just after the next falling edge.
  task automatic apply(input bit v, input logic [63:0] res, input bit br, input bit wr,
                       input logic [4:0] rd, input bit endp, input bit rfr, input logic [1:0] cap);
    bus.in_valid = v; bus.in_result = res; bus.in_is_branch = br; bus.in_write_rd = wr;
    bus.in_rd = rd; bus.in_end_program = endp; bus.rf_ready = rfr; fwd_capture = cap;
    @(negedge clk); #1;
  endtask

  task automatic idle(input bit rfr, input logic [1:0] cap);
    apply(0, 64'hDEAD_BEEF, 1, 1, 5'd31, 1, rfr, cap);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_result = 0; bus.in_is_branch = 0; bus.in_write_rd = 0;
    bus.in_rd = 0; bus.in_end_program = 0; bus.rf_ready = 1;
    rst = 1;
    idle(1, 0); idle(1, 0);
    rst = 0;
    #1;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_count", retired_count, 0);

    // throughput
    apply(1, 64'h11, 0, 1, 5'd5, 0, 1, 0);
    chk("tp_addr0", bus.rf_waddr, 5);
    chk("tp_data0", bus.rf_wdata, 64'h11);
    apply(1, 64'h22, 0, 1, 5'd6, 0, 1, 0);
    apply(1, 64'h33, 0, 1, 5'd7, 0, 1, 0);
    chk("tp_addr2", bus.rf_waddr, 7);
    idle(1, 0);
    chk("tp_count", retired_count, 3);
    chk("tp_last", last_value, 64'h33);

    // branch with link, then branch to rd=0
    apply(1, 64'h1001, 1, 1, 5'd1, 0, 1, 0);
    chk("br_pc", bus.pc_wdata, 64'h1000);
    chk("br_link", bus.rf_wdata, 64'h1004);
    chk("br_pcwe", bus.pc_we, 1);
    apply(1, 64'h2001, 1, 1, 5'd0, 0, 1, 0);
    chk("br0_we", bus.rf_we, 0);
    chk("br0_pcwe", bus.pc_we, 1);
    idle(1, 0);
    chk("br_count", retired_count, 5);

    // backpressure
    apply(1, 64'hAA, 0, 1, 5'd2, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 64'hBB, 0, 1, 5'd3, 0, 0, 0);
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_hold", bus.rf_wdata, 64'hAA);
    end
    apply(1, 64'hBB, 0, 1, 5'd3, 0, 1, 0);
    chk("bp_next", bus.rf_wdata, 64'hBB);
    chk("bp_last", last_value, 64'hAA);
    idle(1, 0);

    // forwarding capture sees the value from before the commit
    apply(1, 64'h55, 0, 1, 5'd4, 0, 1, 0);
    apply(1, 64'h66, 0, 1, 5'd4, 0, 1, 0);
    idle(1, 2'b11);
    chk("fwd_b0", fwd_buf[63:0], 64'h55);
    chk("fwd_b1", fwd_buf[127:64], 64'h55);
    chk("fwd_last", last_value, 64'h66);
    idle(1, 2'b01);
    chk("fwd_b0_new", fwd_buf[63:0], 64'h66);
    chk("fwd_b1_keep", fwd_buf[127:64], 64'h55);
    idle(1, 0);
    chk("sat_count", retired_count2, 3);
    chk("wide_count", retired_count, 9);

    // halt
    apply(1, 64'h77, 0, 1, 5'd8, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      apply(1, 64'h88, 0, 1, 5'd9, 0, 0, 0);
      chk("drain_ready", bus.in_ready, 0);
      chk("drain_done", done_executing, 0);
    end
    apply(1, 64'h88, 0, 1, 5'd9, 0, 1, 0);
    chk("halt_done", done_executing, 1);
    for (int i = 0; i < 3; i++) begin
      apply(1, 64'h99, 0, 1, 5'd10, 0, 1, 0);
      chk("halt_sticky", done_executing, 1);
      chk("halt_nowe", bus.rf_we, 0);
    end
    chk("halt_count", retired_count, 10);

    // reset while draining with a stalled entry
    rst = 1; idle(1, 0); rst = 0;
    apply(1, 64'h99, 0, 1, 5'd11, 1, 1, 0);
    apply(1, 64'hA0, 0, 1, 5'd12, 0, 0, 0);
    rst = 1;
    apply(1, 64'hA0, 0, 1, 5'd12, 0, 0, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_count", retired_count, 0);
    chk("rst_buf", fwd_buf[63:0], 0);
    chk("rst_last", last_value, 0);
    rst = 0;
    #1;
    chk("rst_ready", bus.in_ready, 1);
    apply(1, 64'h12, 0, 1, 5'd9, 0, 1, 0);
    idle(1, 0);
    chk("resume_count", retired_count, 1);
    chk("resume_last", last_value, 64'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Parametrised writeback stage sitting between the memory stage and the register file / PC.
- Accepts one result per cycle over a valid/ready handshake and holds it in a one-entry output register.
- Commits each result to the register file and PC when downstream accepts it.
- Maintains NUM_FWD_BUF capture buffers of the last committed value, a retired-instruction counter, and a RUN/DRAIN/DONE halt machine.

Parameters:
XLEN, 64, datapath width in bits
REG_AW, 5, register address width
NUM_FWD_BUF, 2, number of forwarding capture buffers (>=1)
CNT_W, 32, retired-instruction counter width
INSN_BYTES, 4, instruction size added to form the link value

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  memory-stage result valid
in_ready  output  1  writeback can accept a result this cycle
in_result  input  XLEN  result value, or branch target if in_is_branch
in_is_branch  input  1  result is a jump/branch target
in_write_rd  input  1  result (or link) is written to rd
in_rd  input  REG_AW  destination register
in_end_program  input  1  this result is the final instruction
rf_ready  input  1  register file / PC accept the held entry
rf_we  output  1  register write enable
rf_waddr  output  REG_AW  register write address
rf_wdata  output  XLEN  register write data
pc_we  output  1  PC redirect enable
pc_wdata  output  XLEN  PC redirect target
fwd_capture  input  NUM_FWD_BUF  per-buffer capture strobe
fwd_buf  output  NUM_FWD_BUF*XLEN  capture buffers, buffer i at [i*XLEN +: XLEN]
last_value  output  XLEN  most recently committed rf_wdata
retired_count  output  CNT_W  committed instruction count
done_executing  output  1  program has ended and drained

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state updates occur on posedge `clk`.
- Reset values:
  - Output register empty (`hold_valid` = 0).
  - All outputs 0.
  - State = RUN.
  - `in_ready` = 1 in the cycle after reset deasserts.
- Accept: a handshake (`acc`) occurs when `in_valid && in_ready`.
  - `in_ready` = (state==RUN) && (!hold_valid || rf_ready).
  - This gives full throughput when `rf_ready` stays high.
- Output register loads on `acc`:
  - `target` = {in_result[XLEN-1:1], 1'b0}.
  - `wdata` = in_is_branch ? target + INSN_BYTES (mod 2^XLEN) : in_result.
  - `we` = in_write_rd && (in_rd != 0).
  - `pc_we` = in_is_branch.
  - `pc_wdata` = target.
  - `end` flag = in_end_program.
- Output gating: rf_we = hold_valid && we; pc_we = hold_valid && is_branch. Addr/data fields are 0 when empty. Latency is one cycle from acc to outputs.
- Commit occurs when `hold_valid && rf_ready`.
  - On commit: retired_count += 1, saturating at all-ones.
  - If `we`, last_value <= wdata.
  - hold_valid clears unless a new acc occurs in the same cycle.
- Stall: if `!rf_ready`, every held output stays stable and no acc occurs.
- Forwarding buffers: when fwd_capture[i]=1, fwd_buf[i] <= last_value as registered before this edge, i.e. the old value, even if a commit updates last_value in the same cycle. Multiple strobes may fire together.
- FSM:
  - RUN → DRAIN on acc with in_end_program=1. No further accepts after that.
  - DRAIN → DONE on commit of the end entry.
  - DONE is absorbing until rst; done_executing=1 only in DONE.
  - If the end entry is accepted while a prior entry is held, the prior entry commits first (single entry, so acc only occurs when it is leaving).
- Reset mid-operation (any state, including stalled) discards the held entry, returns to RUN, and clears counters and buffers.
- Input fields are ignored when in_valid=0.

Test Plan:
- Throughput: 3 back-to-back writes (rd=5/6/7, data 0x11/0x22/0x33), rf_ready=1 → rf_we one cycle later on consecutive cycles with matching addr/data; retired_count=3; last_value=0x33.
- Branch: in_is_branch=1, in_result=0x1001, rd=1 → pc_wdata=0x1000, pc_we=1, rf_wdata=0x1004; with rd=0 → rf_we=0, pc_we=1, count increments.
- Backpressure: hold rf_ready=0 for 4 cycles with entry 0xAA held and in_valid=1 → in_ready=0, outputs stable; rf_ready=1 → 0xAA commits, next entry accepted the same cycle.
- Forwarding: commit 0x55 then 0x66 with fwd_capture=2'b11 on the 0x66 commit cycle → both buffers=0x55; strobe buf0 next cycle → buf0=0x66, buf1=0x55.
- Halt: end-program entry with rf_ready=0 for 2 cycles → state DRAIN, done_executing=0, in_ready=0; rf_ready=1 → done_executing=1 next cycle and sticky; further in_valid is ignored.
- Reset/saturation: CNT_W=2, 5 commits → retired_count=3; rst in DRAIN with a stalled entry → all outputs 0, in_ready=1 next cycle.
